// File: rtl/mem_dump_display_pkg.sv
// mem_dump_display_pkg
//   Shared definitions for the post-execution memory viewer:
//   - viewer FSM state encoding
//   - active-low 7-segment glyphs, bit order {g,f,e,d,c,b,a}
//   - index-width helper and its default value
//   - hex-to-glyph decode function
package mem_dump_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_SHOW  = 2'd3
  } state_e;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;  // lowercase b
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;  // lowercase d
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Width of an index that counts 0..n-1 (never narrower than 1 bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEFAULT_IDX_W = idx_width(16);

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] g;
    g = SEG_BLANK;
    case (nib)
      4'h0: g = SEG_0;
      4'h1: g = SEG_1;
      4'h2: g = SEG_2;
      4'h3: g = SEG_3;
      4'h4: g = SEG_4;
      4'h5: g = SEG_5;
      4'h6: g = SEG_6;
      4'h7: g = SEG_7;
      4'h8: g = SEG_8;
      4'h9: g = SEG_9;
      4'hA: g = SEG_A;
      4'hB: g = SEG_B;
      4'hC: g = SEG_C;
      4'hD: g = SEG_D;
      4'hE: g = SEG_E;
      default: g = SEG_F;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/mem_dump_display_seg_scan_mux.sv
// seg_scan_mux
//   Multiplexed 7-segment driver. Lights one digit at a time for SCAN_DIV
//   cycles, stepping from digit 0 (least-significant nibble) upwards and
//   wrapping. sel and leds are registered together so digit enable and
//   segment pattern always change on the same edge (no ghosting).
// Ports:
//   clk       system clock
//   rst_ni    synchronous active-low reset
//   en_i      scan enable; when low the display is blanked and the scan restarts
//   nibbles_i DIGITS hex nibbles, digit 0 in bits [3:0]
//   sel_o     digit enables, one-hot active-low
//   leds_o    segments {g..a}, active-low
module seg_scan_mux
  import mem_dump_display_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic [4*DIGITS-1:0]   nibbles_i,
  output logic [DIGITS-1:0]     sel_o,
  output logic [6:0]            leds_o
);

  localparam int CNT_W = idx_width(SCAN_DIV);
  localparam int DIG_W = idx_width(DIGITS);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DIG_W-1:0]  digit_q, digit_d;
  logic [DIGITS-1:0] sel_q, sel_d;
  logic [6:0]        leds_q, leds_d;
  logic [3:0]        cur_nib;

  assign cur_nib = nibbles_i[{digit_q, 2'b00} +: 4];

  always_comb begin
    cnt_d   = '0;
    digit_d = '0;
    sel_d   = '1;
    leds_d  = SEG_BLANK;
    if (en_i) begin
      sel_d  = ~(DIGITS'(1) << digit_q);
      leds_d = seg_decode(cur_nib);
      if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
        cnt_d   = '0;
        digit_d = (digit_q == DIG_W'(DIGITS - 1)) ? '0 : digit_q + DIG_W'(1);
      end else begin
        cnt_d   = cnt_q + CNT_W'(1);
        digit_d = digit_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      digit_q <= '0;
      sel_q   <= '1;
      leds_q  <= SEG_BLANK;
    end else begin
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
      sel_q   <= sel_d;
      leds_q  <= leds_d;
    end
  end

  assign sel_o  = sel_q;
  assign leds_o = leds_q;

endmodule

// File: rtl/mem_dump_display.sv
// mem_dump_display
//   Post-execution memory viewer. After the CPU raises start, reads one word
//   of a NUM_WORDS-deep window (BASE_ADDR + index*STRIDE) and shows it on a
//   multiplexed DIGITS-digit 7-segment display. next/prev step through the
//   window with wrap-around; page selects the low or high 4*DIGITS-bit half.
//   Optional build macro MEM_DUMP_AUTO_STEP_EN adds parameter AUTO_PERIOD and
//   an automatic forward step after AUTO_PERIOD idle cycles in SHOW.
// Ports:
//   clk          system clock
//   reset        synchronous active-low reset
//   start        CPU finished (level, latched by leaving IDLE)
//   next, prev   step forward / backward (debounced, synchronised)
//   page         0 = low field, 1 = high field of the shown word
//   mem_rd_en    one-cycle read strobe
//   mem_addr     read address
//   mem_rd_data  read data, valid one cycle after mem_rd_en
//   cur_index    window index currently displayed
//   sel          digit enables, one-hot active-low
//   leds         segments {g..a}, active-low
module mem_dump_display
  import mem_dump_display_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                DIGITS    = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_0004,
  parameter int                STRIDE    = 4,
  parameter int                NUM_WORDS = 16,
  parameter int                SCAN_DIV  = 50000
`ifdef MEM_DUMP_AUTO_STEP_EN
  ,
  parameter int                AUTO_PERIOD = 50_000_000
`endif
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         next,
  input  logic                         prev,
  input  logic                         page,
  output logic                         mem_rd_en,
  output logic [ADDR_W-1:0]            mem_addr,
  input  logic [DATA_W-1:0]            mem_rd_data,
  output logic [idx_width(NUM_WORDS)-1:0] cur_index,
  output logic [DIGITS-1:0]            sel,
  output logic [6:0]                   leds
);

  localparam int IDX_W   = idx_width(NUM_WORDS);
  localparam int FIELD_W = 4 * DIGITS;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]  word_q, word_d;
  logic               next_dly_q, prev_dly_q;
  logic               next_edge, prev_edge;
  logic               step_fwd, step_bwd;
  logic               auto_fire;
  logic [2*FIELD_W-1:0] word_ext;
  logic [FIELD_W-1:0]   field;

  // One-cycle delayed copies give single-cycle rising-edge pulses.
  assign next_edge = next & ~next_dly_q;
  assign prev_edge = prev & ~prev_dly_q;

`ifdef MEM_DUMP_AUTO_STEP_EN
  localparam int AUTO_W = idx_width(AUTO_PERIOD + 1);
  logic [AUTO_W-1:0] auto_cnt_q, auto_cnt_d;

  // Counter is zero on every entry to SHOW because it is held clear elsewhere.
  always_comb begin
    auto_cnt_d = '0;
    auto_fire  = 1'b0;
    if (state_q == ST_SHOW && !next_edge && !prev_edge) begin
      if (auto_cnt_q == AUTO_W'(AUTO_PERIOD)) begin
        auto_fire = 1'b1;
      end else begin
        auto_cnt_d = auto_cnt_q + AUTO_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) auto_cnt_q <= '0;
    else        auto_cnt_q <= auto_cnt_d;
  end
`else
  assign auto_fire = 1'b0;
`endif

  // Simultaneous next and prev edges cancel out.
  assign step_fwd = (next_edge & ~prev_edge) | auto_fire;
  assign step_bwd = prev_edge & ~next_edge;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        word_d  = mem_rd_data;
        state_d = ST_SHOW;
      end
      default: begin  // ST_SHOW
        if (step_fwd) begin
          idx_d   = (idx_q == IDX_W'(NUM_WORDS - 1)) ? '0 : idx_q + IDX_W'(1);
          state_d = ST_FETCH;
        end else if (step_bwd) begin
          idx_d   = (idx_q == '0) ? IDX_W'(NUM_WORDS - 1) : idx_q - IDX_W'(1);
          state_d = ST_FETCH;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      word_q     <= '0;
      next_dly_q <= 1'b0;
      prev_dly_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      word_q     <= word_d;
      next_dly_q <= next;
      prev_dly_q <= prev;
    end
  end

  assign mem_rd_en = (state_q == ST_FETCH);
  assign mem_addr  = BASE_ADDR + ADDR_W'(STRIDE) * ADDR_W'(idx_q);
  assign cur_index = idx_q;

  // Pad the word so the high page exists even when DATA_W < 8*DIGITS.
  generate
    if (DATA_W >= 2 * FIELD_W) begin : g_ext_trunc
      assign word_ext = word_d[2*FIELD_W-1:0];
    end else begin : g_ext_pad
      assign word_ext = {{(2 * FIELD_W - DATA_W){1'b0}}, word_d};
    end
  endgenerate

  // The scan mux registers its outputs, so it is fed next-cycle values; the
  // new word and blanking then appear on the same edge as the state change.
  assign field = page ? word_ext[2*FIELD_W-1:FIELD_W] : word_ext[FIELD_W-1:0];

  seg_scan_mux #(
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clk       (clk),
    .rst_ni    (reset),
    .en_i      (state_d != ST_IDLE),
    .nibbles_i (field),
    .sel_o     (sel),
    .leds_o    (leds)
  );

endmodule

// File: doc/mem_dump_display.md
Name: mem_dump_display

Overview:
- Post-execution memory viewer. Once the CPU signals completion, it walks a window of data-memory words and shows each word on a multiplexed 7-segment display.
- Parametrised successor to the fixed 4-digit, single-step, forward-only viewer. Adds:
  - configurable base, stride and depth;
  - configurable digit count;
  - forward and backward stepping with wrap-around;
  - an explicit read handshake with data memory;
  - high/low half paging for words wider than the display.
- Sits at top level between the CPU done flag, data-memory read port and board display pins.

Parameters:
- ADDR_W, 32, memory address width.
- DATA_W, 32, memory word width; must be a multiple of 4 and ≥ 4*DIGITS.
- DIGITS, 4, number of 7-segment digits; 1..8.
- BASE_ADDR, 32'h0000_0004, address of window entry 0.
- STRIDE, 4, byte distance between consecutive entries.
- NUM_WORDS, 16, window depth; ≥ 2.
- SCAN_DIV, 50000, clk cycles each digit is lit.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- start  in  1  level; CPU finished execution; sampled every cycle.
- next  in  1  step forward; already debounced and synchronised.
- prev  in  1  step backward; already debounced and synchronised.
- page  in  1  0 = show least-significant 4*DIGITS bits, 1 = next 4*DIGITS bits.
- mem_rd_en  out  1  one-cycle read strobe.
- mem_addr  out  ADDR_W  read address.
- mem_rd_data  in  DATA_W  valid exactly one cycle after mem_rd_en.
- cur_index  out  $clog2(NUM_WORDS)  index currently displayed.
- sel  out  DIGITS  digit enables; one-hot, active-low.
- leds  out  7  segments {g..a}; active-low.

Behaviour:
- Reset (reset == 0 at a clk edge), regardless of state:
  - state = IDLE; cur_index = 0; mem_rd_en = 0; mem_addr = BASE_ADDR;
  - shown word = 0; sel = all 1s; leds = 7'h7F; scan counter = 0.
- Edge detection: next and prev are acted on at their rising edge only, via a one-cycle registered delay. A held button produces one step.
- FSM:
  - IDLE: display blank. When start == 1, go to FETCH; start is latched, and deasserting it later has no effect until reset.
  - FETCH: mem_rd_en = 1 for exactly one cycle; mem_addr = BASE_ADDR + cur_index*STRIDE, truncated to ADDR_W. Go to WAIT.
  - WAIT: capture mem_rd_data into the shown-word register. Go to SHOW.
  - SHOW: hold the display.
    - next edge alone: cur_index = (cur_index == NUM_WORDS-1) ? 0 : cur_index+1; go to FETCH.
    - prev edge alone: cur_index = (cur_index == 0) ? NUM_WORDS-1 : cur_index-1; go to FETCH.
    - next and prev edges in the same cycle: ignored, no state change.
- Edges arriving in FETCH or WAIT are dropped, not queued.
- Latency: start seen → new value displayed 3 cycles later (FETCH, WAIT, SHOW).
- Paging: the displayed nibble field is the shown word bits [page*4*DIGITS +: 4*DIGITS]. page is applied combinationally from SHOW. It does not re-read memory.
- Scan:
  - A counter advances the active digit every SCAN_DIV cycles, from digit 0 (least-significant nibble) to DIGITS-1, then wraps to 0.
  - sel and leds are registered and update together, so there is no ghosting.
  - Scanning is off in IDLE.
- Decoding: hex 0..F, standard 7-segment glyphs with lowercase b and d.

Optional Feature:
- Macro: MEM_DUMP_AUTO_STEP_EN.
- Defined:
  - Adds parameter AUTO_PERIOD (default 50_000_000).
  - In SHOW, a free-running counter forces a forward step after AUTO_PERIOD cycles with no button edge.
  - Any next or prev edge, and any entry to SHOW, clears the counter.
  - The counter is reset to 0.
- Undefined: no counter logic; steps occur only on button edges.

Decomposition:
- Shared package/header:
  - FSM state encodings (IDLE = 0, FETCH = 1, WAIT = 2, SHOW = 3);
  - 7-segment glyph constants SEG_0..SEG_F and SEG_BLANK (7'h7F);
  - a localparam for index width.
- Sub-module seg_scan_mux:
  - inputs: nibble bus, enable;
  - contains: scan counter, digit select, hex decode;
  - outputs: sel and leds.
- mem_dump_display keeps the FSM, index arithmetic, edge detect and the read port.

Test Plan:
- Reset held low for 3 cycles → sel = 4'hF, leds = 7'h7F, mem_rd_en = 0, cur_index = 0. start is asserted but reset stays 0 → state remains IDLE.
- Memory[0x4] = 32'hCAFE_1234; raise start → mem_rd_en pulses one cycle with mem_addr = 0x4. After 3 cycles the digits scan 4,3,2,1. With page = 1 the digits show E,F,A,C and mem_rd_en stays 0.
- 16 next edges from index 0 → addresses 0x8, 0xC … 0x40, then wrap to 0x4; cur_index returns to 0.
- prev edge at index 0 → cur_index = 15, mem_addr = 0x40. next held 1000 cycles → exactly one step.
- next and prev rising in the same cycle → no mem_rd_en, cur_index unchanged. A next edge during WAIT → dropped.
- Reset driven low during WAIT → next cycle IDLE, display blank. Auto step enabled with AUTO_PERIOD = 20 → index increments every 23 cycles with no input.
